// File: rtl/pauli_correction_scheduler.sv
// ---------------------------------------------------------------------------
// pauli_correction_scheduler
//
// Buffers Pauli corrections coming from the qhttp handshake FSM and hands
// them to the QCI pulse controller in arrival order over a valid/ready link.
// A correction whose deadline cannot be met with ISSUE_GUARD cycles of margin
// is dropped and reported on the expire port instead of being issued.
// Identity corrections (pauli == I) are retired silently.
//
// Datapath: DEPTH-entry circular FIFO -> single output register -> FSM.
// The output register holds the entry currently being judged or offered, so
// the block can retain DEPTH+1 corrections in total.
//
// Ports
//   clk_1g           system clock (sole clock)
//   rst              synchronous, active-high reset
//   now_cycles       free-running system timebase (never wraps)
//   flush            emergency drop of all queued and in-flight work
//   enq_valid        correction pulse; upstream cannot be stalled
//   enq_qubit_id     qubit id of the correction
//   enq_pauli        00=I 01=X 10=Z 11=Y
//   enq_deadline     absolute coherence deadline on the timebase
//   enq_ready        FIFO not full (informational only)
//   gate_valid       correction offered to the pulse controller
//   gate_ready       pulse controller accepts the offer
//   gate_qubit_id    id of the offered correction
//   gate_pauli       gate of the offered correction
//   expire_valid     one-cycle pulse: head entry dropped as late
//   expire_qubit_id  id of the expired entry
//   cnt_issued       completed non-I handshakes, saturating
//   cnt_expired      expiries, saturating
//   cnt_overflow     enqueues dropped because the FIFO was full, saturating
// ---------------------------------------------------------------------------
module pauli_correction_scheduler #(
  parameter int DEPTH       = 8,
  parameter int ID_W        = 128,
  parameter int TIME_W      = 64,
  parameter int ISSUE_GUARD = 16
) (
  input  logic              clk_1g,
  input  logic              rst,
  input  logic [TIME_W-1:0] now_cycles,
  input  logic              flush,
  input  logic              enq_valid,
  input  logic [ID_W-1:0]   enq_qubit_id,
  input  logic [1:0]        enq_pauli,
  input  logic [TIME_W-1:0] enq_deadline,
  output logic              enq_ready,
  output logic              gate_valid,
  input  logic              gate_ready,
  output logic [ID_W-1:0]   gate_qubit_id,
  output logic [1:0]        gate_pauli,
  output logic              expire_valid,
  output logic [ID_W-1:0]   expire_qubit_id,
  output logic [15:0]       cnt_issued,
  output logic [15:0]       cnt_expired,
  output logic [15:0]       cnt_overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [TIME_W:0]   GUARD_C = (TIME_W + 1)'(ISSUE_GUARD);
  localparam logic [1:0]        PAULI_I = 2'b00;

  // S_CHECK is the cycle in which the freshly popped entry sits in the
  // output register and its late/identity verdict is acted on.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_ISSUE  = 2'd2,
    S_EXPIRE = 2'd3
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   qubit_id;
    logic [1:0]        pauli;
    logic [TIME_W-1:0] deadline;
  } entry_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic full;
  logic non_empty;
  logic push;
  logic pop;
  logic overflow;
  logic head_late;

  state_t state_q;
  state_t state_d;

  logic [ID_W-1:0] out_id_q;
  logic [1:0]      out_pauli_q;
  logic            out_late_q;

  logic issue_fire;
  logic expire_fire;

  assign full      = (count_q == DEPTH_C);
  assign non_empty = (count_q != '0);
  assign head      = mem[rd_ptr_q];

  // Fullness is judged on the count at cycle start, so an enqueue while full
  // is lost even if the head is popped in the same cycle. During flush the
  // enqueue is discarded without being treated as an overflow.
  assign push     = enq_valid & ~full & ~flush;
  assign overflow = enq_valid &  full & ~flush;
  assign pop      = (state_q == S_IDLE) & non_empty & ~flush;

  // Widen by one bit so now+guard cannot wrap around the deadline compare.
  assign head_late = ({1'b0, head.deadline} < ({1'b0, now_cycles} + GUARD_C));

  // NOTE: storage carries no reset; validity is tracked by count_q and the
  // pointers, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk_1g) begin
    if (push) begin
      mem[wr_ptr_q] <= '{qubit_id: enq_qubit_id,
                         pauli:    enq_pauli,
                         deadline: enq_deadline};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_1g) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output register: loaded on pop with the payload and the late verdict
  // taken against the timebase at the moment of the pop.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_1g) begin
    if (rst) begin
      out_id_q    <= '0;
      out_pauli_q <= '0;
      out_late_q  <= 1'b0;
    end else if (pop) begin
      out_id_q    <= head.qubit_id;
      out_pauli_q <= head.pauli;
      out_late_q  <= head_late;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_1g) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state. Flush overrides everything, including an offer that
  // would otherwise have to stay valid until accepted.
  // -------------------------------------------------------------------------
  // NOTE: state_d takes a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (non_empty) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (out_late_q)                  state_d = S_EXPIRE;
        else if (out_pauli_q == PAULI_I) state_d = S_IDLE;
        else                             state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (gate_ready) state_d = S_IDLE;
      end
      S_EXPIRE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    enq_ready       = ~full;
    gate_valid      = (state_q == S_ISSUE);
    expire_valid    = (state_q == S_EXPIRE);
    gate_qubit_id   = out_id_q;
    gate_pauli      = out_pauli_q;
    expire_qubit_id = out_id_q;
  end

  // -------------------------------------------------------------------------
  // Statistics. A handshake or expiry coinciding with flush is discarded and
  // therefore not counted.
  // -------------------------------------------------------------------------
  assign issue_fire  = (state_q == S_ISSUE)  & gate_ready & ~flush;
  assign expire_fire = (state_q == S_EXPIRE) & ~flush;

  always_ff @(posedge clk_1g) begin
    if (rst) begin
      cnt_issued   <= '0;
      cnt_expired  <= '0;
      cnt_overflow <= '0;
    end else begin
      if (issue_fire)  cnt_issued   <= sat_inc(cnt_issued);
      if (expire_fire) cnt_expired  <= sat_inc(cnt_expired);
      if (overflow)    cnt_overflow <= sat_inc(cnt_overflow);
    end
  end

endmodule

// File: tb/tb_pauli_correction_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pauli_correction_scheduler
//
// Directed stimulus with a scoreboard. Each stimulus step that should
// produce an offer or an expiry pushes the hand-computed payload into a
// queue; a monitor on the falling edge pops and compares whenever the DUT
// completes a handshake or pulses expire_valid, and flags any offer or
// expiry that has no pending expectation.
// ---------------------------------------------------------------------------
module tb_pauli_correction_scheduler;

  localparam int ID_W   = 128;
  localparam int TIME_W = 64;

  typedef logic [ID_W-1:0] val_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      pauli;
  } gate_exp_t;

  logic              clk_1g = 1'b0;
  logic              rst;
  logic [TIME_W-1:0] now_cycles;
  logic              flush;
  logic              enq_valid;
  logic [ID_W-1:0]   enq_qubit_id;
  logic [1:0]        enq_pauli;
  logic [TIME_W-1:0] enq_deadline;
  logic              enq_ready;
  logic              gate_valid;
  logic              gate_ready;
  logic [ID_W-1:0]   gate_qubit_id;
  logic [1:0]        gate_pauli;
  logic              expire_valid;
  logic [ID_W-1:0]   expire_qubit_id;
  logic [15:0]       cnt_issued;
  logic [15:0]       cnt_expired;
  logic [15:0]       cnt_overflow;

  gate_exp_t exp_gate[$];
  val_t      exp_expire[$];
  gate_exp_t mon_g;
  val_t      mon_x;

  int n_pass  = 0;
  int n_total = 0;

  pauli_correction_scheduler #(
    .DEPTH       (8),
    .ID_W        (ID_W),
    .TIME_W      (TIME_W),
    .ISSUE_GUARD (16)
  ) dut (
    .clk_1g          (clk_1g),
    .rst             (rst),
    .now_cycles      (now_cycles),
    .flush           (flush),
    .enq_valid       (enq_valid),
    .enq_qubit_id    (enq_qubit_id),
    .enq_pauli       (enq_pauli),
    .enq_deadline    (enq_deadline),
    .enq_ready       (enq_ready),
    .gate_valid      (gate_valid),
    .gate_ready      (gate_ready),
    .gate_qubit_id   (gate_qubit_id),
    .gate_pauli      (gate_pauli),
    .expire_valid    (expire_valid),
    .expire_qubit_id (expire_qubit_id),
    .cnt_issued      (cnt_issued),
    .cnt_expired     (cnt_expired),
    .cnt_overflow    (cnt_overflow)
  );

  always #5 clk_1g = ~clk_1g;

  task automatic check(input string name, input val_t actual, input val_t expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk_1g);
    #1;
  endtask

  task automatic enq(input val_t id, input logic [1:0] p, input logic [TIME_W-1:0] dl);
    enq_valid    = 1'b1;
    enq_qubit_id = id;
    enq_pauli    = p;
    enq_deadline = dl;
    tick();
    enq_valid    = 1'b0;
  endtask

  task automatic expect_gate(input val_t id, input logic [1:0] p);
    gate_exp_t e;
    e.id    = id;
    e.pauli = p;
    exp_gate.push_back(e);
  endtask

  task automatic wait_issued(input int target, input int budget, input string name);
    int n = 0;
    while (cnt_issued != 16'(target) && n < budget) begin
      tick();
      n++;
    end
    check(name, val_t'(cnt_issued), val_t'(target));
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk_1g) begin
    if (!rst && !flush) begin
      if (gate_valid) begin
        if (exp_gate.size() == 0) begin
          n_total++;
          $display("FAIL gate_unexpected: got offer id %0h expected no offer", gate_qubit_id);
        end else if (gate_ready) begin
          mon_g = exp_gate.pop_front();
          check("sb_gate_id", gate_qubit_id, mon_g.id);
          check("sb_gate_pauli", val_t'(gate_pauli), val_t'(mon_g.pauli));
        end
      end
      if (expire_valid) begin
        if (exp_expire.size() == 0) begin
          n_total++;
          $display("FAIL expire_unexpected: got expiry id %0h expected none", expire_qubit_id);
        end else begin
          mon_x = exp_expire.pop_front();
          check("sb_expire_id", expire_qubit_id, mon_x);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    now_cycles   = 64'd100;
    flush        = 1'b0;
    enq_valid    = 1'b0;
    enq_qubit_id = '0;
    enq_pauli    = 2'b00;
    enq_deadline = '0;
    gate_ready   = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_gate_valid",   val_t'(gate_valid),   val_t'(0));
    check("rst_expire_valid", val_t'(expire_valid), val_t'(0));
    check("rst_enq_ready",    val_t'(enq_ready),    val_t'(1));
    check("rst_cnt_issued",   val_t'(cnt_issued),   val_t'(0));
    check("rst_cnt_overflow", val_t'(cnt_overflow), val_t'(0));
    rst = 1'b0;
    tick();

    // 1: on-time X correction, latency enq edge t -> valid after edge t+2
    gate_ready = 1'b1;
    expect_gate(val_t'(1), 2'b01);
    enq(val_t'(1), 2'b01, 64'd1000);
    check("t1_valid_after_t",  val_t'(gate_valid), val_t'(0));
    tick();
    check("t1_valid_after_t1", val_t'(gate_valid), val_t'(0));
    tick();
    check("t1_valid_after_t2", val_t'(gate_valid), val_t'(1));
    check("t1_gate_id",        gate_qubit_id,      val_t'(1));
    check("t1_gate_pauli",     val_t'(gate_pauli), val_t'(2'b01));
    tick();
    check("t1_valid_drops",    val_t'(gate_valid), val_t'(0));
    check("t1_cnt_issued",     val_t'(cnt_issued), val_t'(1));

    // 2: deadline 110 < 100+16 -> expiry, no offer
    exp_expire.push_back(val_t'(2));
    enq(val_t'(2), 2'b10, 64'd110);
    tick();
    tick();
    check("t2_expire_valid", val_t'(expire_valid), val_t'(1));
    check("t2_expire_id",    expire_qubit_id,      val_t'(2));
    check("t2_no_gate",      val_t'(gate_valid),   val_t'(0));
    tick();
    check("t2_expire_pulse", val_t'(expire_valid), val_t'(0));
    check("t2_cnt_expired",  val_t'(cnt_expired),  val_t'(1));
    check("t2_cnt_issued",   val_t'(cnt_issued),   val_t'(1));

    // 3: stalled consumer, 10 back-to-back enqs -> 9 retained, 1 overflow
    gate_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) expect_gate(val_t'(10 + i), 2'b01);
      enq(val_t'(10 + i), 2'b01, '1);
    end
    check("t3_cnt_overflow", val_t'(cnt_overflow), val_t'(1));
    check("t3_enq_ready",    val_t'(enq_ready),    val_t'(0));
    check("t3_head_offered", val_t'(gate_valid),   val_t'(1));
    check("t3_head_id",      gate_qubit_id,        val_t'(10));
    gate_ready = 1'b1;
    wait_issued(10, 100, "t3_cnt_issued");
    tick();
    check("t3_enq_ready_after", val_t'(enq_ready), val_t'(1));
    check("t3_queue_drained",   val_t'(exp_gate.size()), val_t'(0));

    // 4: identity retired silently, Y issued
    enq(val_t'(30), 2'b00, 64'd1000);
    expect_gate(val_t'(31), 2'b11);
    enq(val_t'(31), 2'b11, 64'd1000);
    wait_issued(11, 20, "t4_cnt_issued");
    repeat (4) tick();
    check("t4_cnt_issued_stable", val_t'(cnt_issued),  val_t'(11));
    check("t4_cnt_expired",       val_t'(cnt_expired), val_t'(1));

    // 5: flush with an offer pending and 3 queued, plus a same-cycle enq
    gate_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_gate(val_t'(40 + i), 2'b01);
      enq(val_t'(40 + i), 2'b01, 64'd1000);
    end
    tick();
    check("t5_offer_pending", val_t'(gate_valid), val_t'(1));
    check("t5_offer_id",      gate_qubit_id,      val_t'(40));
    flush        = 1'b1;
    enq_valid    = 1'b1;
    enq_qubit_id = val_t'(44);
    enq_pauli    = 2'b01;
    enq_deadline = 64'd1000;
    exp_gate.delete();
    tick();
    flush     = 1'b0;
    enq_valid = 1'b0;
    check("t5_gate_valid",    val_t'(gate_valid),   val_t'(0));
    check("t5_expire_valid",  val_t'(expire_valid), val_t'(0));
    check("t5_enq_ready",     val_t'(enq_ready),    val_t'(1));
    check("t5_cnt_issued",    val_t'(cnt_issued),   val_t'(11));
    check("t5_cnt_expired",   val_t'(cnt_expired),  val_t'(1));
    check("t5_cnt_overflow",  val_t'(cnt_overflow), val_t'(1));
    gate_ready = 1'b1;
    repeat (8) tick();
    check("t5_fifo_empty",    val_t'(gate_valid),   val_t'(0));
    check("t5_issued_after",  val_t'(cnt_issued),   val_t'(11));

    // 6: reset while offering
    gate_ready = 1'b0;
    expect_gate(val_t'(50), 2'b10);
    enq(val_t'(50), 2'b10, 64'd1000);
    enq(val_t'(51), 2'b01, 64'd1000);
    tick();
    check("t6_offer_pending", val_t'(gate_valid), val_t'(1));
    rst = 1'b1;
    exp_gate.delete();
    exp_expire.delete();
    tick();
    check("t6_gate_valid",    val_t'(gate_valid),   val_t'(0));
    check("t6_expire_valid",  val_t'(expire_valid), val_t'(0));
    check("t6_enq_ready",     val_t'(enq_ready),    val_t'(1));
    check("t6_gate_id",       gate_qubit_id,        val_t'(0));
    check("t6_cnt_issued",    val_t'(cnt_issued),   val_t'(0));
    check("t6_cnt_expired",   val_t'(cnt_expired),  val_t'(0));
    check("t6_cnt_overflow",  val_t'(cnt_overflow), val_t'(0));
    rst        = 1'b0;
    gate_ready = 1'b1;
    tick();
    expect_gate(val_t'(60), 2'b01);
    enq(val_t'(60), 2'b01, 64'd1000);
    wait_issued(1, 20, "t6_new_issue");
    repeat (4) tick();

    check("end_gate_queue_empty",   val_t'(exp_gate.size()),   val_t'(0));
    check("end_expire_queue_empty", val_t'(exp_expire.size()), val_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
